// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the accumulate stage
//
// Purpose: single place for the FSM state type and the default datapath widths
//          used by mac_accumulator and acc_sat_add.
// Contents:
//   state_t      - IDLE / ACCUM / DONE
//   DEF_PROD_W   - product width (matches the multiplier output)
//   DEF_ACC_W    - accumulator width
//   DEF_LEN_W    - job length field width
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_PROD_W = 32;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/mac_accumulator_acc_sat_add.sv
// rtl/mac_accumulator_acc_sat_add.sv - combinational accumulator adder with carry-out and optional clamp
//
// Purpose: adds a zero-extended product to the running sum at ACC_W+1 bits.
//          The extra bit is the carry-out that feeds the sticky overflow flag.
// Configuration macro: MAC_ACCUMULATOR_SATURATE_EN
//   defined   - on carry-out the sum clamps to all ones
//   undefined - the sum wraps modulo 2^ACC_W
// Ports:
//   i_acc   in  ACC_W   current accumulator value
//   i_prod  in  PROD_W  unsigned product to add
//   o_sum   out ACC_W   next accumulator value
//   o_carry out 1       carry-out of the ACC_W-bit add
module acc_sat_add
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    assign o_carry = w_full[ACC_W];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    // Once clamped, any non-zero add carries again, so the sum stays pinned.
    assign o_sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - registered accumulate stage downstream of the 16x16 multiplier
//
// Purpose: sums a programmed number of unsigned products arriving on a
//          valid/ready stream and presents the total on a valid/ready output.
// Configuration macro: MAC_ACCUMULATOR_SATURATE_EN (clamp instead of wrap,
//          implemented in acc_sat_add; handshakes and timing unchanged).
// Ports:
//   clk        in  1       rising-edge clock
//   rst        in  1       synchronous active-high reset
//   start      in  1       begin a job (sampled only in IDLE)
//   len        in  LEN_W   products in the job, latched on start
//   p_in       in  PROD_W  unsigned product
//   p_valid    in  1       p_in valid
//   p_ready    out 1       p_in accepted this cycle when p_valid is high
//   acc_out    out ACC_W   accumulated sum
//   acc_valid  out 1       acc_out is a final result
//   acc_ready  in  1       consumer takes the result
//   busy       out 1       state is not IDLE
//   ovf        out 1       sticky overflow flag for the current job
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] p_in,
    input  logic              p_valid,
    output logic              p_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              ovf
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [LEN_W-1:0]   r_rem;

    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    acc_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_prod  (p_in),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        r_rem <= len;
                        // An empty job goes straight to DONE and returns zero.
                        r_state <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    // p_ready is high throughout ACCUM, so p_valid alone is the handshake.
                    if (p_valid) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_carry;
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of registered state: no input-to-output path.
    assign p_ready   = (r_state == ACCUM);
    assign acc_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - scoreboard bench for mac_accumulator
module tb_mac_accumulator;

    localparam int AW  = 40;
    localparam int AW2 = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [7:0]    len;
    logic [31:0]   p_in;
    logic          p_valid;
    logic          p_ready;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          acc_ready;
    logic          busy;
    logic          ovf;

    logic           s_start;
    logic [7:0]     s_len;
    logic [31:0]    s_p_in;
    logic           s_p_valid;
    logic           s_p_ready;
    logic [AW2-1:0] s_acc_out;
    logic           s_acc_valid;
    logic           s_acc_ready;
    logic           s_busy;
    logic           s_ovf;

    mac_accumulator #(.PROD_W(32), .ACC_W(AW), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .busy      (busy),
        .ovf       (ovf)
    );

    mac_accumulator #(.PROD_W(32), .ACC_W(AW2), .LEN_W(8)) dut34 (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .len       (s_len),
        .p_in      (s_p_in),
        .p_valid   (s_p_valid),
        .p_ready   (s_p_ready),
        .acc_out   (s_acc_out),
        .acc_valid (s_acc_valid),
        .acc_ready (s_acc_ready),
        .busy      (s_busy),
        .ovf       (s_ovf)
    );

    int total = 0;
    int bad   = 0;

    // Expected results as {ovf, acc_out}.
    logic [AW:0]  q_main[$];
    logic [AW2:0] q_34[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && acc_valid && acc_ready) begin
            if (q_main.size() == 0) begin
                total++;
                bad++;
                $display("FAIL main_unexpected_result actual=%h expected=none", {ovf, acc_out});
            end else begin
                chk("main_result", 64'({ovf, acc_out}), 64'(q_main.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s_acc_valid && s_acc_ready) begin
            if (q_34.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w34_unexpected_result actual=%h expected=none", {s_ovf, s_acc_out});
            end else begin
                chk("w34_result", 64'({s_ovf, s_acc_out}), 64'(q_34.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic main_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic main_feed(input logic [31:0] v);
        int n;
        n       = 0;
        p_valid = 1'b1;
        p_in    = v;
        while (!p_ready && n < 50) begin
            tick();
            n++;
        end
        if (!p_ready) begin
            total++;
            bad++;
            $display("FAIL feed_timeout actual=p_ready_low expected=p_ready_high");
        end
        tick();
        p_valid = 1'b0;
    endtask

    logic [AW2:0] exp34;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; p_in = '0; p_valid = 1'b0; acc_ready = 1'b0;
        s_start = 1'b0; s_len = '0; s_p_in = '0; s_p_valid = 1'b0; s_acc_ready = 1'b0;
        tick();
        tick();
        chk("reset_acc_out", 64'(acc_out), 64'h0);
        chk("reset_acc_valid", 64'(acc_valid), 64'h0);
        chk("reset_p_ready", 64'(p_ready), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_ovf", 64'(ovf), 64'h0);
        rst = 1'b0;
        tick();

        // Basic job.
        acc_ready = 1'b1;
        q_main.push_back({1'b0, 40'h00033EB560});
        main_start(8'd2);
        chk("t1_p_ready_after_start", 64'(p_ready), 64'h1);
        chk("t1_busy", 64'(busy), 64'h1);
        main_feed(32'h00001900);
        chk("t1_no_early_valid", 64'(acc_valid), 64'h0);
        main_feed(32'h033E9C60);
        chk("t1_valid_after_last", 64'(acc_valid), 64'h1);
        chk("t1_acc_out", 64'(acc_out), 64'h00033EB560);
        chk("t1_ovf", 64'(ovf), 64'h0);
        tick();
        chk("t1_idle_after_handshake", 64'(busy), 64'h0);

        // Backpressure on both sides.
        acc_ready = 1'b0;
        q_main.push_back({1'b0, 40'd6});
        main_start(8'd3);
        for (int i = 0; i < 5; i++) begin
            p_valid = (i % 2 == 0);
            p_in    = 32'(i / 2 + 1);
            tick();
        end
        p_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 64'(acc_valid), 64'h1);
            chk("t2_hold_acc_out", 64'(acc_out), 64'd6);
            tick();
        end
        acc_ready = 1'b1;
        tick();
        chk("t2_idle_after_ready", 64'(busy), 64'h0);

        // Empty job.
        acc_ready = 1'b0;
        q_main.push_back({1'b0, 40'd0});
        main_start(8'd0);
        chk("t3_valid", 64'(acc_valid), 64'h1);
        chk("t3_no_p_ready", 64'(p_ready), 64'h0);
        chk("t3_acc_out_zero", 64'(acc_out), 64'h0);
        acc_ready = 1'b1;
        tick();
        chk("t3_idle", 64'(busy), 64'h0);

        // Overflow on the 34-bit instance.
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        exp34 = {1'b1, 34'h3FFFFFFFF};
`else
        exp34 = {1'b1, 34'h0FFFFFFFB};
`endif
        s_acc_ready = 1'b1;
        q_34.push_back(exp34);
        s_start = 1'b1;
        s_len   = 8'd5;
        tick();
        s_start   = 1'b0;
        s_p_valid = 1'b1;
        s_p_in    = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        s_p_valid = 1'b0;
        chk("t4_valid", 64'(s_acc_valid), 64'h1);
        chk("t4_ovf", 64'(s_ovf), 64'h1);
        chk("t4_acc_out", 64'(s_acc_out), 64'(exp34[AW2-1:0]));
        tick();
        chk("t4_idle", 64'(s_busy), 64'h0);

        // Reset mid-job.
        acc_ready = 1'b1;
        main_start(8'd4);
        main_feed(32'd1);
        main_feed(32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_acc_out", 64'(acc_out), 64'h0);
        chk("t5_acc_valid", 64'(acc_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_ovf", 64'(ovf), 64'h0);
        chk("t5_p_ready", 64'(p_ready), 64'h0);
        q_main.push_back({1'b0, 40'h1900});
        main_start(8'd1);
        main_feed(32'h1900);
        chk("t5_new_job", 64'(acc_out), 64'h1900);
        tick();

        // Stray starts in ACCUM and DONE.
        acc_ready = 1'b0;
        q_main.push_back({1'b0, 40'h30});
        main_start(8'd2);
        main_feed(32'h10);
        start = 1'b1;
        len   = 8'd0;
        tick();
        start = 1'b0;
        chk("t6_still_accum", 64'(p_ready), 64'h1);
        main_feed(32'h20);
        chk("t6_sum", 64'(acc_out), 64'h30);
        start = 1'b1;
        len   = 8'd3;
        tick();
        start = 1'b0;
        chk("t6_done_valid", 64'(acc_valid), 64'h1);
        chk("t6_done_acc_out", 64'(acc_out), 64'h30);
        acc_ready = 1'b1;
        tick();
        chk("t6_idle", 64'(busy), 64'h0);

        tick();
        tick();
        chk("main_queue_drained", 64'(q_main.size()), 64'h0);
        chk("w34_queue_drained", 64'(q_34.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
